pmod_adder_stim: RTL and testbench
==================================

Name: pmod_adder_stim

Overview:
- Stimulus and checker for the PMOD half-adder demo.
- Drives the four PMOD control lines (input A, input B, run/stop, reset) that the demo board samples.
- Reads back the sum and carry LED lines, synchronises them, and compares them against expected values.
- Sits on a second iCEstick or in the same FPGA as a loopback self-test master; reports pass/fail and an error count.

Parameters:
- HOLD_CYCLES, 6000000, clk cycles each vector is held (0.5 s at 12 MHz); must be >= SETTLE_CYCLES+2
- SETTLE_CYCLES, 4, cycles after driving a vector before sampling; must be >= 3 to cover the 2-flop synchroniser
- RST_CYCLES, 8, cycles pmod_reset is held high at sequence start
- LOOPS, 1, number of passes over the 4-vector set; 0 = run until stop

Ports:
- clk  in  1  12 MHz system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a sequence; ignored while busy
- stop  in  1  level; aborts a running sequence
- sum_in  in  1  demo sum line (LED1), asynchronous to clk
- carry_in  in  1  demo carry line (LED2), asynchronous to clk
- pmod_a  out  1  drives demo input A
- pmod_b  out  1  drives demo input B
- pmod_runstop  out  1  drives demo run/stop (1 = stopped)
- pmod_reset  out  1  drives demo reset (active high)
- busy  out  1  high from the cycle after start until DONE or IDLE
- pass  out  1  sequence completed with err_cnt==0
- fail  out  1  at least one mismatch since the last start
- err_cnt  out  4  saturating mismatch count
- vec_idx  out  2  current vector index; {pmod_a,pmod_b} = vec_idx

Behaviour:
- Reset (async assert, sync deassert via the clk domain):
  - State IDLE.
  - pmod_a=pmod_b=0, pmod_runstop=1, pmod_reset=0.
  - busy=pass=fail=0, err_cnt=0, vec_idx=0.
  - Synchroniser flops and all counters cleared.
- sum_in and carry_in each pass through a 2-flop synchroniser. Only the synchronised copies are used.
- FSM states: IDLE, RST, DRIVE, SAMPLE, HOLD, DONE.
- IDLE:
  - On start=1 and stop=0: clear err_cnt, pass and fail; set vec_idx=0 and the loop counter to 0; go to RST.
  - start while stop=1 is ignored.
- RST:
  - pmod_reset=1, pmod_runstop=1 for exactly RST_CYCLES cycles.
  - Then pmod_reset=0 and pmod_runstop=0; go to DRIVE.
- DRIVE:
  - {pmod_a,pmod_b}=vec_idx; wait SETTLE_CYCLES cycles.
  - Then go to SAMPLE.
- SAMPLE, one cycle:
  - Expected sum = pmod_a^pmod_b; expected carry = pmod_a&pmod_b.
  - On any mismatch: err_cnt increments, saturating at 15, and fail is set (sticky).
  - Go to HOLD.
- HOLD: remain until the cycle counter measured from DRIVE entry reaches HOLD_CYCLES-1. Then:
  - vec_idx<3: vec_idx++, go to DRIVE.
  - vec_idx==3: vec_idx wraps to 0 and the loop counter increments. Go to DONE if LOOPS!=0 and the loop counter reaches LOOPS; otherwise go to DRIVE.
- DONE:
  - One cycle: pass = (err_cnt==0), busy drops, pmod_runstop=1.
  - pmod_a and pmod_b keep their last values.
  - Go to IDLE. pass and fail persist until the next start.
- stop=1 in any state other than IDLE:
  - Next cycle: state IDLE, busy=0, pmod_runstop=1, pmod_reset=0.
  - pass stays 0; fail and err_cnt keep their values.
  - A stop that coincides with a SAMPLE cycle still records that comparison.
- start and stop asserted in the same cycle in IDLE: stop wins, and no sequence begins.
- A mid-sequence reset_n assertion returns every output to its reset value immediately.
- Every output is registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package pmod_demo_pkg holds:
  - the state enum;
  - PMOD pin index constants (A=0, B=1, RUNSTOP=2, RESET=3);
  - ERR_W=4;
  - the default clock-rate constant CLK_HZ=12000000.
- One sub-module, sync2: a 2-flop synchroniser with async active-low reset. It is instantiated once per readback line.

Test Plan:
- Loopback model (sum=a^b, carry=a&b, 2-cycle delay), HOLD_CYCLES=20, LOOPS=1, pulse start:
  - pmod_reset high for 8 cycles;
  - vec_idx steps 0,1,2,3 at 20-cycle intervals;
  - DONE gives pass=1, fail=0, err_cnt=0, busy=0.
- Carry stuck at 0 in the model: only vector 3 mismatches, giving err_cnt=1, fail=1, pass=0.
- Sum inverted in the model, LOOPS=5: 20 mismatches, so err_cnt saturates at 15 and fail=1.
- stop asserted during the DRIVE of vector 2:
  - next cycle state=IDLE, busy=0, pmod_runstop=1;
  - err_cnt unchanged, pass=0.
- start and stop high together in IDLE: busy stays 0 and pmod_reset never rises. A start pulse while busy=1 causes no restart (vec_idx continues).
- reset_n pulsed low mid-HOLD: all outputs return to their reset values in the same cycle, without waiting for a clk edge.

Source files
------------

// File: rtl/pmod_demo_pkg.sv
// Shared types and constants for the PMOD half-adder demo stimulus block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pmod_demo_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Bit positions of the four PMOD control lines in the output pin register
    localparam int PIN_A       = 0;
    localparam int PIN_B       = 1;
    localparam int PIN_RUNSTOP = 2;
    localparam int PIN_RESET   = 3;

    // Width of the saturating mismatch counter
    localparam int ERR_W = 4;

    // Board clock rate; default hold time is half a second of this
    localparam int CLK_HZ = 12000000;

    // Width of the loop counter; LOOPS values beyond this range are not supported
    localparam int LOOP_W = 16;

endpackage

// File: rtl/pmod_adder_stim_sync2.sv
// Two-flop synchroniser for one asynchronous readback line.
// Latency: 2 clk cycles from input change to output.
// Backpressure: none; free-running.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First stage may go metastable; second stage gives it a cycle to resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pmod_adder_stim.sv
// Drives the half-adder demo's PMOD inputs through all four vectors and checks sum/carry readback.
// Latency: every output is registered; status updates one clk after the deciding event.
// Backpressure: none; start ignored while busy, stop aborts any running sequence next cycle.
module pmod_adder_stim
    import pmod_demo_pkg::*;
#(
    parameter int HOLD_CYCLES   = CLK_HZ / 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int RST_CYCLES    = 8,
    parameter int LOOPS         = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             sum_in,
    input  logic             carry_in,
    output logic             pmod_a,
    output logic             pmod_b,
    output logic             pmod_runstop,
    output logic             pmod_reset,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
);

    // One counter serves both the reset pulse and the per-vector hold time
    localparam int CNT_MAX = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_LIMIT  = LOOP_W'(LOOPS);
    localparam logic [ERR_W-1:0]  ERR_SAT     = '1;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [LOOP_W-1:0]  loop_cnt, loop_nx;
    logic [3:0]         pins, pins_nx;
    logic [1:0]         vec, vec_nx;
    logic [ERR_W-1:0]   err, err_nx;
    logic               busy_r, busy_nx;
    logic               pass_r, pass_nx;
    logic               fail_r, fail_nx;

    logic               sum_s;
    logic               carry_s;
    logic               mismatch;
    logic [LOOP_W-1:0]  loop_inc;
    logic [1:0]         vec_inc;

    sync2 u_sync_sum (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (sum_in),
        .q     (sum_s)
    );

    sync2 u_sync_carry (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (carry_in),
        .q     (carry_s)
    );

    // Compare readback against the half-adder function of what is currently driven
    always_comb begin
        mismatch = (sum_s   != (pins[PIN_A] ^ pins[PIN_B])) ||
                   (carry_s != (pins[PIN_A] & pins[PIN_B]));
    end

    // Next-state and next-output logic; stop overrides the normal flow at the end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        loop_nx  = loop_cnt;
        pins_nx  = pins;
        vec_nx   = vec;
        err_nx   = err;
        busy_nx  = busy_r;
        pass_nx  = pass_r;
        fail_nx  = fail_r;
        loop_inc = loop_cnt + 1'b1;
        vec_inc  = vec + 1'b1;

        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nx           = ST_RST;
                    cnt_nx             = '0;
                    loop_nx            = '0;
                    vec_nx             = 2'd0;
                    err_nx             = '0;
                    pass_nx            = 1'b0;
                    fail_nx            = 1'b0;
                    busy_nx            = 1'b1;
                    pins_nx[PIN_RESET]   = 1'b1;
                    pins_nx[PIN_RUNSTOP] = 1'b1;
                end
            end

            ST_RST: begin
                if (cnt == RST_LAST) begin
                    state_nx             = ST_DRIVE;
                    cnt_nx               = '0;
                    pins_nx[PIN_RESET]   = 1'b0;
                    pins_nx[PIN_RUNSTOP] = 1'b0;
                    pins_nx[PIN_A]       = vec[1];
                    pins_nx[PIN_B]       = vec[0];
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            ST_DRIVE: begin
                // Counter keeps running so HOLD measures from DRIVE entry
                cnt_nx = cnt + 1'b1;
                if (cnt == SETTLE_LAST) begin
                    state_nx = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                cnt_nx   = cnt + 1'b1;
                state_nx = ST_HOLD;
                if (mismatch) begin
                    fail_nx = 1'b1;
                    if (err != ERR_SAT) begin
                        err_nx = err + 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_nx = '0;
                    if (vec != 2'd3) begin
                        state_nx       = ST_DRIVE;
                        vec_nx         = vec_inc;
                        pins_nx[PIN_A] = vec_inc[1];
                        pins_nx[PIN_B] = vec_inc[0];
                    end else begin
                        vec_nx  = 2'd0;
                        loop_nx = loop_inc;
                        if ((LOOPS != 0) && (loop_inc == LOOP_LIMIT)) begin
                            // A/B keep the last vector on the board
                            state_nx             = ST_DONE;
                            busy_nx              = 1'b0;
                            pass_nx              = (err == '0);
                            pins_nx[PIN_RUNSTOP] = 1'b1;
                        end else begin
                            state_nx       = ST_DRIVE;
                            pins_nx[PIN_A] = 1'b0;
                            pins_nx[PIN_B] = 1'b0;
                        end
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end

            ST_DONE: begin
                state_nx = ST_IDLE;
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Abort: the SAMPLE comparison above is kept, everything else parks the board
        if (stop && (state == ST_RST || state == ST_DRIVE ||
                     state == ST_SAMPLE || state == ST_HOLD)) begin
            state_nx             = ST_IDLE;
            cnt_nx               = '0;
            busy_nx              = 1'b0;
            pass_nx              = 1'b0;
            pins_nx[PIN_RUNSTOP] = 1'b1;
            pins_nx[PIN_RESET]   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            loop_cnt <= '0;
            pins     <= 4'b0100;
            vec      <= 2'd0;
            err      <= '0;
            busy_r   <= 1'b0;
            pass_r   <= 1'b0;
            fail_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            loop_cnt <= loop_nx;
            pins     <= pins_nx;
            vec      <= vec_nx;
            err      <= err_nx;
            busy_r   <= busy_nx;
            pass_r   <= pass_nx;
            fail_r   <= fail_nx;
        end
    end

    assign pmod_a       = pins[PIN_A];
    assign pmod_b       = pins[PIN_B];
    assign pmod_runstop = pins[PIN_RUNSTOP];
    assign pmod_reset   = pins[PIN_RESET];
    assign busy         = busy_r;
    assign pass         = pass_r;
    assign fail         = fail_r;
    assign err_cnt      = err;
    assign vec_idx      = vec;

endmodule

// File: tb/tb_pmod_adder_stim.sv
// Bench for pmod_adder_stim: two instances (LOOPS=1 and LOOPS=5) each looped back through a half-adder model.
// Latency: model adds 2 clk of delay ahead of the DUT's own synchronisers.
// Backpressure: n/a.
module tb_pmod_adder_stim;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic stop;
    logic start0, start1;
    int   mode;   // 0 = good adder, 1 = carry stuck at 0, 2 = sum inverted
    int   inst;   // which instance the helper selectors look at

    logic a0, b0, rs0, rst0, busy0, pass0, fail0;
    logic a1, b1, rs1, rst1, busy1, pass1, fail1;
    logic [3:0] err0, err1;
    logic [1:0] vec0, vec1;
    logic sum0, carry0, sum1, carry1;

    // Loopback models: registered half adder followed by one more register
    logic [1:0] m0a = 2'b00, m0b = 2'b00, m1a = 2'b00, m1b = 2'b00;
    always @(posedge clk) begin
        m0a <= {a0 ^ b0, a0 & b0};
        m0b <= m0a;
        m1a <= {a1 ^ b1, a1 & b1};
        m1b <= m1a;
    end
    assign sum0   = m0b[1] ^ (mode == 2);
    assign carry0 = m0b[0] & (mode != 1);
    assign sum1   = m1b[1] ^ (mode == 2);
    assign carry1 = m1b[0] & (mode != 1);

    pmod_adder_stim #(.HOLD_CYCLES(20), .SETTLE_CYCLES(4), .RST_CYCLES(8), .LOOPS(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start0), .stop(stop),
        .sum_in(sum0), .carry_in(carry0),
        .pmod_a(a0), .pmod_b(b0), .pmod_runstop(rs0), .pmod_reset(rst0),
        .busy(busy0), .pass(pass0), .fail(fail0), .err_cnt(err0), .vec_idx(vec0)
    );

    pmod_adder_stim #(.HOLD_CYCLES(20), .SETTLE_CYCLES(4), .RST_CYCLES(8), .LOOPS(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop),
        .sum_in(sum1), .carry_in(carry1),
        .pmod_a(a1), .pmod_b(b1), .pmod_runstop(rs1), .pmod_reset(rst1),
        .busy(busy1), .pass(pass1), .fail(fail1), .err_cnt(err1), .vec_idx(vec1)
    );

    logic s_a, s_b, s_rs, s_rst, s_busy, s_pass, s_fail;
    logic [3:0] s_err;
    logic [1:0] s_vec;
    always_comb begin
        s_a    = (inst == 1) ? a1    : a0;
        s_b    = (inst == 1) ? b1    : b0;
        s_rs   = (inst == 1) ? rs1   : rs0;
        s_rst  = (inst == 1) ? rst1  : rst0;
        s_busy = (inst == 1) ? busy1 : busy0;
        s_pass = (inst == 1) ? pass1 : pass0;
        s_fail = (inst == 1) ? fail1 : fail0;
        s_err  = (inst == 1) ? err1  : err0;
        s_vec  = (inst == 1) ? vec1  : vec0;
    end

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        int    inst;
        int    mode;
        int    exp_err;
        int    exp_pass;
        int    exp_fail;
        int    exp_cyc;
    } run_t;

    run_t tbl[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        if (i == 1) start1 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Counts cycles until busy drops; an expired budget is a failed comparison
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (s_busy && cyc < budget) begin
            step();
            cyc++;
        end
        if (s_busy) chk("done_timeout", 1, 0);
    endtask

    task automatic wait_vec(input logic [1:0] v, input int budget);
        int n = 0;
        while (s_vec != v && n < budget) begin
            step();
            n++;
        end
        if (s_vec != v) chk("vec_timeout", int'(s_vec), int'(v));
    endtask

    initial begin
        int cyc, rc, first_run, t, seen, dropped;
        logic [1:0] last;
        int chg[$];

        tbl[0] = '{"good",        0, 0, 0,  1, 0, 88};
        tbl[1] = '{"carry0",      0, 1, 1,  0, 1, 88};
        tbl[2] = '{"suminv_x5",   1, 2, 15, 0, 1, 408};
        tbl[3] = '{"suminv_x1",   0, 2, 4,  0, 1, 88};
        tbl[4] = '{"good_again",  0, 0, 0,  1, 0, 88};

        inst = 0; mode = 0;
        start0 = 1'b0; start1 = 1'b0; stop = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_a",       int'(a0),   0);
        chk("rst_b",       int'(b0),   0);
        chk("rst_runstop", int'(rs0),  1);
        chk("rst_reset",   int'(rst0), 0);
        chk("rst_busy",    int'(busy0), 0);
        chk("rst_pass",    int'(pass0), 0);
        chk("rst_fail",    int'(fail0), 0);
        chk("rst_err",     int'(err0), 0);
        chk("rst_vec",     int'(vec0), 0);
        reset_n = 1'b1;
        repeat (3) step();

        // Full sequences from the table
        for (int i = 0; i < 5; i++) begin
            inst = tbl[i].inst;
            mode = tbl[i].mode;
            repeat (4) step();
            pulse_start(inst);
            chk({tbl[i].name, "_busy_up"}, int'(s_busy), 1);
            wait_done(1000, cyc);
            chk({tbl[i].name, "_cycles"}, cyc, tbl[i].exp_cyc);
            chk({tbl[i].name, "_err"},  int'(s_err),  tbl[i].exp_err);
            chk({tbl[i].name, "_pass"}, int'(s_pass), tbl[i].exp_pass);
            chk({tbl[i].name, "_fail"}, int'(s_fail), tbl[i].exp_fail);
            chk({tbl[i].name, "_runstop"}, int'(s_rs), 1);
            step();
            chk({tbl[i].name, "_pass_holds"}, int'(s_pass), tbl[i].exp_pass);
        end

        // Detailed timing of one good pass
        inst = 0; mode = 0;
        repeat (3) step();
        pulse_start(0);
        rc = 0; first_run = -1; t = 0; last = s_vec;
        chg.delete();
        while (s_busy && t < 200) begin
            if (s_rst) rc++;
            if (!s_rs && first_run < 0) first_run = t;
            if (s_vec != last) begin
                chg.push_back(t);
                last = s_vec;
            end
            step();
            t++;
        end
        chk("reset_pulse_len", rc, 8);
        chk("runstop_low_at", first_run, 8);
        chk("vec_changes", chg.size(), 3);
        if (chg.size() == 3) begin
            chk("vec1_at", chg[0], 28);
            chk("vec2_at", chg[1], 48);
            chk("vec3_at", chg[2], 68);
        end
        chk("done_at", t, 88);
        chk("done_a_kept", int'(s_a), 1);
        chk("done_b_kept", int'(s_b), 1);
        chk("done_pass", int'(s_pass), 1);

        // Stop during DRIVE of vector 2, with every vector mismatching
        mode = 2;
        repeat (3) step();
        pulse_start(0);
        wait_vec(2'd2, 200);
        chk("pre_stop_a", int'(s_a), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy",    int'(s_busy), 0);
        chk("stop_runstop", int'(s_rs),   1);
        chk("stop_reset",   int'(s_rst),  0);
        chk("stop_err",     int'(s_err),  2);
        chk("stop_pass",    int'(s_pass), 0);
        chk("stop_fail",    int'(s_fail), 1);
        repeat (25) step();
        chk("stop_stays_idle", int'(s_busy), 0);
        chk("stop_err_kept",   int'(s_err),  2);

        // start and stop together in IDLE: nothing begins, status untouched
        mode = 0;
        stop = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        stop = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (s_busy || s_rst) seen++;
            step();
        end
        chk("start_stop_ignored", seen, 0);
        chk("start_stop_err_kept", int'(s_err), 2);

        // start while busy does not restart the sequence
        pulse_start(0);
        wait_vec(2'd1, 200);
        pulse_start(0);
        rc = 0; dropped = 0; t = 0;
        while (s_busy && t < 200) begin
            if (s_rst) rc++;
            if (s_vec == 2'd0) dropped++;
            step();
            t++;
        end
        chk("restart_no_reset", rc, 0);
        chk("restart_no_vec0", dropped, 0);
        chk("restart_remaining", t, 59);
        chk("restart_pass", int'(s_pass), 1);

        // Asynchronous reset mid-HOLD clears outputs without a clk edge
        mode = 2;
        repeat (3) step();
        pulse_start(0);
        wait_vec(2'd1, 200);
        repeat (10) step();
        chk("pre_arst_busy", int'(s_busy), 1);
        chk("pre_arst_err",  int'(s_err),  2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_a",       int'(a0),    0);
        chk("arst_b",       int'(b0),    0);
        chk("arst_runstop", int'(rs0),   1);
        chk("arst_reset",   int'(rst0),  0);
        chk("arst_busy",    int'(busy0), 0);
        chk("arst_fail",    int'(fail0), 0);
        chk("arst_err",     int'(err0),  0);
        chk("arst_vec",     int'(vec0),  0);
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("post_arst_idle", int'(busy0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
